// File: rtl/m72_pkg.sv
// Shared types and helpers for the M72 layer mixer: palette channel codes,
// priority source encoding and the 5-to-8 bit colour expansion.
package m72_pkg;

  localparam logic [1:0] PAL_R = 2'd0;
  localparam logic [1:0] PAL_G = 2'd1;
  localparam logic [1:0] PAL_B = 2'd2;

  typedef enum logic [2:0] {
    SRC_A_HI,
    SRC_B_HI,
    SRC_OBJ,
    SRC_A,
    SRC_B
  } src_e;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb555_t;

  // Replicating the top bits spreads 0..31 evenly over 0..255.
  function automatic logic [7:0] pal_expand5to8(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

endpackage

// File: rtl/dpramv.sv
// Generic dual-port RAM: port A is the read/write CPU side, port B is a
// read-only side with a clock enable. Both read ports are registered.
module dpramv #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clock_a,
  input  logic [AW-1:0] address_a,
  input  logic [DW-1:0] data_a,
  input  logic          wren_a,
  output logic [DW-1:0] q_a,
  input  logic          clock_b,
  input  logic          enable_b,
  input  logic [AW-1:0] address_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock_a) begin
    if (wren_a) mem[address_a] <= data_a;
    q_a <= mem[address_a];
  end

  // Same-edge write on port A is not yet visible here: port B sees the old word.
  always_ff @(posedge clock_b) begin
    if (enable_b) q_b <= mem[address_b];
  end

endmodule

// File: rtl/m72_palette_ram.sv
// RGB555 palette: one 5-bit RAM per channel, CPU on port A, video on port B.
module m72_palette_ram
  import m72_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] cpu_addr,
  input  logic [4:0]    cpu_din,
  input  logic [2:0]    cpu_we,
  output rgb555_t       cpu_q,
  input  logic          vid_ce,
  input  logic [AW-1:0] vid_addr,
  output rgb555_t       vid_q
);

  dpramv #(.DW(5), .AW(AW)) u_pal_r (
    .clock_a(clk), .address_a(cpu_addr), .data_a(cpu_din), .wren_a(cpu_we[PAL_R]),
    .q_a(cpu_q.r),
    .clock_b(clk), .enable_b(vid_ce), .address_b(vid_addr), .q_b(vid_q.r)
  );

  dpramv #(.DW(5), .AW(AW)) u_pal_g (
    .clock_a(clk), .address_a(cpu_addr), .data_a(cpu_din), .wren_a(cpu_we[PAL_G]),
    .q_a(cpu_q.g),
    .clock_b(clk), .enable_b(vid_ce), .address_b(vid_addr), .q_b(vid_q.g)
  );

  dpramv #(.DW(5), .AW(AW)) u_pal_b (
    .clock_a(clk), .address_a(cpu_addr), .data_a(cpu_din), .wren_a(cpu_we[PAL_B]),
    .q_a(cpu_q.b),
    .clock_b(clk), .enable_b(vid_ce), .address_b(vid_addr), .q_b(vid_q.b)
  );

endmodule

// File: rtl/m72_layer_mixer.sv
// M72 layer mixer: per-pixel priority between two tile layers and the object
// stream, palette lookup and blank-gated RGB888 output with a 2-pixel latency.
module m72_layer_mixer
  import m72_pkg::*;
#(
  parameter int PAL_AW      = 9,
  parameter bit BLANK_BLACK = 1'b1
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        CE_PIX,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic [19:0] A,
  input  logic [1:0]  BYTE_SEL,
  input  logic        RD,
  input  logic        WR,
  input  logic [3:0]  A_BIT,
  input  logic [3:0]  A_COL,
  input  logic        A_CP15,
  input  logic        A_CP8,
  input  logic [3:0]  B_BIT,
  input  logic [3:0]  B_COL,
  input  logic        B_CP15,
  input  logic        B_CP8,
  input  logic [3:0]  OBJ_BIT,
  input  logic [3:0]  OBJ_COL,
  input  logic        HBLANK,
  input  logic        VBLANK,
  input  logic [2:0]  LAYER_EN,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        HB_O,
  output logic        VB_O
);

  // Priority resolution
  logic a_op, b_op, o_op, a_hi, b_hi;
  src_e       src;
  logic [8:0] mix_idx;

  assign a_op = (A_BIT != 4'd0) && LAYER_EN[0];
  assign b_op = (B_BIT != 4'd0) && LAYER_EN[1];
  assign o_op = (OBJ_BIT != 4'd0) && LAYER_EN[2];
  assign a_hi = a_op && (A_CP15 || (A_CP8 && A_BIT[3]));
  assign b_hi = b_op && (B_CP15 || (B_CP8 && B_BIT[3]));

  always_comb begin
    src = SRC_B;
    if (a_hi)      src = SRC_A_HI;
    else if (b_hi) src = SRC_B_HI;
    else if (o_op) src = SRC_OBJ;
    else if (a_op) src = SRC_A;
  end

  // SRC_B doubles as the backdrop: a transparent B still supplies its colour bank.
  always_comb begin
    mix_idx = {1'b1, B_COL, b_op ? B_BIT : 4'd0};
    case (src)
      SRC_A_HI, SRC_A: mix_idx = {1'b1, A_COL, A_BIT};
      SRC_B_HI:        mix_idx = {1'b1, B_COL, B_BIT};
      SRC_OBJ:         mix_idx = {1'b0, OBJ_COL, OBJ_BIT};
      default:         ;
    endcase
  end

  // CPU decode
  logic       wr_q;
  logic       wr_pulse;
  logic [2:0] cpu_we;
  logic [1:0] cpu_ch;
  rgb555_t    cpu_q;
  logic       rd_q;
  logic [1:0] rd_ch_q;
  logic [4:0] cpu_rd_val;
  logic [15:0] dout_hold;
  logic       unused_cpu;

  assign cpu_ch   = A[11:10];
  assign wr_pulse = WR && !wr_q && BYTE_SEL[0];
  assign cpu_we[PAL_R] = wr_pulse && (cpu_ch == PAL_R);
  assign cpu_we[PAL_G] = wr_pulse && (cpu_ch == PAL_G);
  assign cpu_we[PAL_B] = wr_pulse && (cpu_ch == PAL_B);
  assign unused_cpu = ^{A[19:12], A[0], DIN[15:5], BYTE_SEL[1]};

  always_comb begin
    cpu_rd_val = 5'd0;
    case (rd_ch_q)
      PAL_R:   cpu_rd_val = cpu_q.r;
      PAL_G:   cpu_rd_val = cpu_q.g;
      PAL_B:   cpu_rd_val = cpu_q.b;
      default: cpu_rd_val = 5'd0;
    endcase
  end

  // The RAM read word arrives the cycle after RD; latch it so DOUT holds afterwards.
  assign DOUT = rd_q ? {11'd0, cpu_rd_val} : dout_hold;

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_ch_q   <= 2'd0;
      dout_hold <= 16'd0;
    end else begin
      wr_q    <= WR;
      rd_q    <= RD;
      rd_ch_q <= cpu_ch;
      if (rd_q) dout_hold <= {11'd0, cpu_rd_val};
    end
  end

  // Video pipeline: S1 index, RAM q (with matching blank stage), S2 output
  logic [PAL_AW-1:0] s1_idx;
  logic              s1_hb, s1_vb;
  logic              m_hb, m_vb;
  rgb555_t           vid_q;

  m72_palette_ram #(.AW(PAL_AW)) u_pal (
    .clk     (CLK_32M),
    .cpu_addr(PAL_AW'(A[9:1])),
    .cpu_din (DIN[4:0]),
    .cpu_we  (cpu_we),
    .cpu_q   (cpu_q),
    .vid_ce  (CE_PIX),
    .vid_addr(s1_idx),
    .vid_q   (vid_q)
  );

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_idx <= '0;
      s1_hb  <= 1'b0;
      s1_vb  <= 1'b0;
      m_hb   <= 1'b0;
      m_vb   <= 1'b0;
      R      <= 8'd0;
      G      <= 8'd0;
      B      <= 8'd0;
      HB_O   <= 1'b1;
      VB_O   <= 1'b1;
    end else if (CE_PIX) begin
      s1_idx <= PAL_AW'(mix_idx);
      s1_hb  <= HBLANK;
      s1_vb  <= VBLANK;
      m_hb   <= s1_hb;
      m_vb   <= s1_vb;
      HB_O   <= m_hb;
      VB_O   <= m_vb;
      if (BLANK_BLACK && (m_hb || m_vb)) begin
        R <= 8'd0;
        G <= 8'd0;
        B <= 8'd0;
      end else begin
        R <= pal_expand5to8(vid_q.r);
        G <= pal_expand5to8(vid_q.g);
        B <= pal_expand5to8(vid_q.b);
      end
    end
  end

endmodule

// File: tb/tb_m72_layer_mixer.sv
// Directed bench for m72_layer_mixer: priority vector table plus CPU port,
// blanking, clock-enable, reset and write/read collision sequences.
module tb_m72_layer_mixer;

  logic        CLK_32M = 1'b0;
  logic        RESET_N = 1'b1;
  logic        CE_PIX;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic [19:0] A;
  logic [1:0]  BYTE_SEL;
  logic        RD, WR;
  logic [3:0]  A_BIT, A_COL, B_BIT, B_COL, OBJ_BIT, OBJ_COL;
  logic        A_CP15, A_CP8, B_CP15, B_CP8;
  logic        HBLANK, VBLANK;
  logic [2:0]  LAYER_EN;
  logic [7:0]  R, G, B;
  logic        HB_O, VB_O;

  m72_layer_mixer #(.PAL_AW(9), .BLANK_BLACK(1'b1)) dut (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX),
    .DIN(DIN), .DOUT(DOUT), .A(A), .BYTE_SEL(BYTE_SEL), .RD(RD), .WR(WR),
    .A_BIT(A_BIT), .A_COL(A_COL), .A_CP15(A_CP15), .A_CP8(A_CP8),
    .B_BIT(B_BIT), .B_COL(B_COL), .B_CP15(B_CP15), .B_CP8(B_CP8),
    .OBJ_BIT(OBJ_BIT), .OBJ_COL(OBJ_COL), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .LAYER_EN(LAYER_EN), .R(R), .G(G), .B(B), .HB_O(HB_O), .VB_O(VB_O)
  );

  // clock / reset
  always #10 CLK_32M = ~CLK_32M;

  typedef struct {
    logic [3:0] a_bit, a_col;
    logic       a_cp15, a_cp8;
    logic [3:0] b_bit, b_col;
    logic       b_cp15, b_cp8;
    logic [3:0] o_bit, o_col;
    logic [2:0] en;
    logic       hb, vb;
    logic [8:0] exp_idx;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [4:0] pal_m [3][512];
  int tests = 0;
  int fails = 0;

  // scoreboard
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] exp_out(input logic [8:0] idx, input logic hb, input logic vb);
    logic [4:0] r5, g5, b5;
    logic [7:0] r8, g8, b8;
    r5 = pal_m[0][idx];
    g5 = pal_m[1][idx];
    b5 = pal_m[2][idx];
    r8 = {r5, r5[4:2]};
    g8 = {g5, g5[4:2]};
    b8 = {b5, b5[4:2]};
    if (hb || vb) begin
      r8 = 8'd0; g8 = 8'd0; b8 = 8'd0;
    end
    return {r8, g8, b8, hb, vb};
  endfunction

  function automatic vec_t mk(input logic [3:0] ab, ac, input logic a15, a8,
                              input logic [3:0] bb, bc, input logic b15, b8,
                              input logic [3:0] ob, oc, input logic [2:0] en,
                              input logic hb, vb, input logic [8:0] idx);
    vec_t v;
    v.a_bit = ab; v.a_col = ac; v.a_cp15 = a15; v.a_cp8 = a8;
    v.b_bit = bb; v.b_col = bc; v.b_cp15 = b15; v.b_cp8 = b8;
    v.o_bit = ob; v.o_col = oc; v.en = en; v.hb = hb; v.vb = vb;
    v.exp_idx = idx;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    A_BIT = v.a_bit; A_COL = v.a_col; A_CP15 = v.a_cp15; A_CP8 = v.a_cp8;
    B_BIT = v.b_bit; B_COL = v.b_col; B_CP15 = v.b_cp15; B_CP8 = v.b_cp8;
    OBJ_BIT = v.o_bit; OBJ_COL = v.o_col; LAYER_EN = v.en;
    HBLANK = v.hb; VBLANK = v.vb;
  endtask

  task automatic cpu_write(input logic [1:0] ch, input logic [8:0] idx,
                           input logic [15:0] data, input logic [1:0] sel);
    @(negedge CLK_32M);
    A = {8'h00, ch, idx, 1'b0};
    DIN = data;
    BYTE_SEL = sel;
    WR = 1'b1;
    @(negedge CLK_32M);
    WR = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] ch, input logic [8:0] idx, output logic [15:0] data);
    @(negedge CLK_32M);
    A = {8'h00, ch, idx, 1'b0};
    RD = 1'b1;
    @(negedge CLK_32M);
    data = DOUT;
    RD = 1'b0;
  endtask

  task automatic settle(input vec_t v);
    @(negedge CLK_32M);
    drive(v);
    repeat (3) @(negedge CLK_32M);
  endtask

  logic [15:0] rd_data;
  logic [4:0]  old_v, new_v;
  vec_t        bd;

  initial begin
    vecs[0]  = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 0, 0, 9'h135);
    vecs[1]  = mk(4'd5, 4'd3, 0, 1, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 0, 0, 9'h062);
    vecs[2]  = mk(4'd9, 4'd3, 0, 1, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 0, 0, 9'h139);
    vecs[3]  = mk(4'd0, 4'd3, 0, 0, 4'd0,  4'd4, 0, 0, 4'd0,  4'd6,  3'b111, 0, 0, 9'h140);
    vecs[4]  = mk(4'd5, 4'd3, 0, 0, 4'd7,  4'd2, 1, 0, 4'd2,  4'd6,  3'b111, 0, 0, 9'h127);
    vecs[5]  = mk(4'd5, 4'd3, 0, 0, 4'd12, 4'd2, 0, 1, 4'd0,  4'd6,  3'b111, 0, 0, 9'h12C);
    vecs[6]  = mk(4'd5, 4'd3, 0, 0, 4'd7,  4'd1, 0, 0, 4'd0,  4'd6,  3'b111, 0, 0, 9'h135);
    vecs[7]  = mk(4'd0, 4'd3, 0, 0, 4'd7,  4'd1, 0, 0, 4'd0,  4'd6,  3'b111, 0, 0, 9'h117);
    vecs[8]  = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b110, 0, 0, 9'h062);
    vecs[9]  = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b010, 0, 0, 9'h117);
    vecs[10] = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b000, 0, 0, 9'h110);
    vecs[11] = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 1, 0, 9'h135);
    vecs[12] = mk(4'd5, 4'd3, 1, 0, 4'd7,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 0, 1, 9'h135);
    vecs[13] = mk(4'd8, 4'd3, 0, 1, 4'd0,  4'd1, 0, 0, 4'd2,  4'd6,  3'b111, 0, 0, 9'h138);
    vecs[14] = mk(4'd0, 4'd3, 0, 0, 4'd0,  4'd1, 0, 0, 4'd15, 4'd15, 3'b111, 0, 0, 9'h0FF);
    vecs[15] = mk(4'd5, 4'd3, 0, 0, 4'd7,  4'd2, 0, 1, 4'd0,  4'd6,  3'b111, 0, 0, 9'h135);

    CE_PIX = 1'b1; DIN = '0; A = '0; BYTE_SEL = 2'b00; RD = 1'b0; WR = 1'b0;
    drive(vecs[3]);

    // reset with the pixel enable toggling
    #2 RESET_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_32M);
      CE_PIX = ~CE_PIX;
    end
    @(negedge CLK_32M);
    check("reset_state", {R, G, B, HB_O, VB_O, DOUT, 6'd0}, {24'h0, 2'b11, 16'h0, 6'd0});
    CE_PIX = 1'b1;
    RESET_N = 1'b1;

    // preload palette and model
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < 512; i++) begin
        pal_m[ch][i] = 5'(((i * 7 + ch * 13 + 5) % 31) + 1);
        cpu_write(2'(ch), 9'(i), {11'd0, pal_m[ch][i]}, 2'b01);
      end
    end

    // write held for 5 clocks, data changed mid-strobe: only the first edge counts
    @(negedge CLK_32M);
    A = 20'h00006; DIN = 16'h001F; BYTE_SEL = 2'b01; WR = 1'b1;
    @(negedge CLK_32M);
    DIN = 16'h000A;
    repeat (4) @(negedge CLK_32M);
    WR = 1'b0;
    pal_m[0][3] = 5'h1F;
    cpu_read(2'd0, 9'd3, rd_data);
    check("cpu_write_once", {32'd0, rd_data}, {32'd0, 16'h001F});

    // DOUT holds while RD is low, even with the address moved
    A = {8'h00, 2'd1, 9'd7, 1'b0};
    @(negedge CLK_32M);
    check("dout_hold", {32'd0, DOUT}, {32'd0, 16'h001F});

    cpu_read(2'd3, 9'd3, rd_data);
    check("cpu_read_unmapped", {32'd0, rd_data}, {32'd0, 16'h0000});

    cpu_write(2'd0, 9'd3, 16'h0005, 2'b10);
    cpu_read(2'd0, 9'd3, rd_data);
    check("cpu_bytesel_ignored", {32'd0, rd_data}, {32'd0, 16'h001F});

    cpu_write(2'd1, 9'd5, 16'hFFE9, 2'b01);
    pal_m[1][5] = 5'h09;
    cpu_read(2'd1, 9'd5, rd_data);
    check("cpu_din_high_ignored", {32'd0, rd_data}, {32'd0, 16'h0009});

    cpu_write(2'd1, 9'h140, 16'h0010, 2'b01);
    pal_m[1][9'h140] = 5'h10;

    // table-driven priority vectors, streamed one per pixel
    for (int i = 0; i < NVEC + 3; i++) begin
      @(negedge CLK_32M);
      if (i >= 3)
        check($sformatf("vec%0d", i - 3), {22'd0, R, G, B, HB_O, VB_O},
              {22'd0, exp_out(vecs[i-3].exp_idx, vecs[i-3].hb, vecs[i-3].vb)});
      if (i < NVEC) drive(vecs[i]);
    end

    // backdrop green from entry 0x140 = 0x10
    settle(vecs[3]);
    check("backdrop_g", {40'd0, G}, {40'd0, 8'h84});

    // one-pixel HBLANK pulse emerges exactly two pixels later, one pixel wide
    settle(vecs[0]);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK_32M);
      if (k >= 1)
        check($sformatf("blank_pulse_%0d", k), {46'd0, HB_O, ({R, G, B} == 24'd0)},
              {46'd0, (k == 5), (k == 5)});
      HBLANK = (k == 2);
    end

    // CE_PIX low freezes all video outputs
    settle(vecs[0]);
    @(negedge CLK_32M);
    CE_PIX = 1'b0;
    drive(vecs[14]);
    HBLANK = 1'b1;
    repeat (3) @(negedge CLK_32M);
    check("ce_hold", {22'd0, R, G, B, HB_O, VB_O}, {22'd0, exp_out(9'h135, 1'b0, 1'b0)});
    CE_PIX = 1'b1;
    repeat (3) @(negedge CLK_32M);
    check("ce_resume", {22'd0, R, G, B, HB_O, VB_O}, {22'd0, exp_out(9'h0FF, 1'b1, 1'b0)});

    // reset mid-frame: black at once, refilled after the pipeline depth
    settle(vecs[0]);
    #2 RESET_N = 1'b0;
    #1 check("reset_midframe", {22'd0, R, G, B, HB_O, VB_O}, {22'd0, 24'd0, 2'b11});
    @(negedge CLK_32M);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_32M);
    check("reset_refill", {22'd0, R, G, B, HB_O, VB_O}, {22'd0, exp_out(9'h135, 1'b0, 1'b0)});

    // CPU writes the entry the video side is reading this very pixel
    bd = mk(4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 3'b111, 0, 0, 9'h100);
    settle(bd);
    old_v = pal_m[0][9'h100];
    new_v = old_v ^ 5'h15;
    A = {8'h00, 2'd0, 9'h100, 1'b0}; DIN = {11'd0, new_v}; BYTE_SEL = 2'b01; WR = 1'b1;
    @(negedge CLK_32M);
    WR = 1'b0;
    @(negedge CLK_32M);
    check("collision_old", {40'd0, R}, {40'd0, old_v, old_v[4:2]});
    @(negedge CLK_32M);
    check("collision_new", {40'd0, R}, {40'd0, new_v, new_v[4:2]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m72_layer_mixer.md
Name: m72_layer_mixer

Overview:
- Consumer end of the tile-layer pixel interface: takes the 4-bit pixel (BIT), colour (COL) and priority flags (CP15, CP8) from two tile layers plus the object (sprite) pixel stream.
- Resolves priority per pixel, looks up a CPU-writable 512-entry RGB555 palette, and emits blank-gated 8-bit RGB to the video output.
- Sits between the layer/object generators and the video timing/scaler stage.

Parameters:
- PAL_AW, 9, palette index width (512 entries per channel)
- BLANK_BLACK, 1, when 1 force RGB to 0 during blanking; when 0 pass palette data through

Ports:
- CLK_32M  in  1  system pixel-domain clock
- RESET_N  in  1  reset; active-low, asynchronous
- CE_PIX  in  1  pixel clock enable
- DIN  in  16  CPU write data
- DOUT  out  16  CPU read data
- A  in  20  CPU byte address; palette decoded from A[11:1]
- BYTE_SEL  in  2  CPU byte lanes
- RD  in  1  CPU read strobe, palette window selected
- WR  in  1  CPU write strobe, palette window selected
- A_BIT, A_COL  in  4,4  layer A pixel and colour
- A_CP15, A_CP8  in  1,1  layer A priority flags
- B_BIT, B_COL  in  4,4  layer B pixel and colour
- B_CP15, B_CP8  in  1,1  layer B priority flags
- OBJ_BIT, OBJ_COL  in  4,4  object pixel and colour
- HBLANK, VBLANK  in  1,1  blanking, aligned with the pixel inputs
- LAYER_EN  in  3  debug enables {obj, B, A}; 0 treats that source as transparent
- R, G, B  out  8,8,8  output colour
- HB_O, VB_O  out  1,1  blanking delayed to match R/G/B

Behaviour:
- Reset: R/G/B=0, HB_O=VB_O=1, DOUT=0, all pipeline registers 0, write-edge flag 0. Palette contents are not reset.
- Transparency: a source is transparent when its BIT==0 or its LAYER_EN bit is 0.
- High-priority rule for a layer pixel: non-transparent AND (CP15 OR (CP8 AND BIT[3])).
- Priority order, first match wins:
  1. A high
  2. B high
  3. obj non-transparent
  4. A non-transparent
  5. B non-transparent
  6. backdrop: layer B index with BIT=0.
- Palette index: obj -> {1'b0, OBJ_COL, OBJ_BIT}; layer X -> {1'b1, X_COL, X_BIT}.
- Pipeline, all stages advance only on CE_PIX:
  - S1: register the index and the blank flags.
  - Palette port B reads the S1 index combinationally-addressed, with registered q.
  - S2: on the next CE_PIX, register the expanded RGB and the blank flags.
  - Latency: inputs sampled at CE_PIX n appear on R/G/B after CE_PIX n+2.
- Expansion: 8-bit channel = {c[4:0], c[4:2]}.
- Blanking: when BLANK_BLACK=1 and (S2 HBLANK or VBLANK), R=G=B=0.
- CPU palette map, A[11:1]:
  - A[11:10]: 0=R, 1=G, 2=B, 3=unmapped (writes ignored, reads return 0).
  - A[9:1]: entry index.
  - Data in DIN[4:0]; a write requires BYTE_SEL[0]; DIN[15:5] ignored.
- Write edge: a write is performed once, on the first CLK_32M cycle WR is high (rising-edge detect). WR held for many cycles = a single write.
- Read: DOUT = {11'b0, entry} one clock after the address is applied with RD high. DOUT holds its last value when RD is low.
- Simultaneous CPU write and video read of the same entry: video gets the old value that cycle, the new value from the next read. There is no stall and no arbitration (true dual port).
- Reset mid-frame: outputs go black immediately; the pipeline refills after 2 CE_PIX once RESET_N deasserts.
- CE_PIX low: all video outputs hold their values.

Decomposition:
- Shared package m72_pkg:
  - palette channel constants PAL_R/PAL_G/PAL_B
  - src_e enum {SRC_A_HI, SRC_B_HI, SRC_OBJ, SRC_A, SRC_B}
  - function pal_expand5to8
- One sub-module, m72_palette_ram: three 512x5 dual-port RAMs built on dpramv, holding the CPU port and the video port. The mixer holds priority logic, pipeline and CPU decode.

Test Plan:
- Reset: hold RESET_N=0, toggle CE_PIX -> R/G/B=0, HB_O=VB_O=1, DOUT=0; release -> first valid RGB after 2 CE_PIX.
- Palette write/read: WR=1 for 5 clocks, A=0x0006, DIN=0x001F, BYTE_SEL=01 -> R entry 3=0x1F written once. RD at same A -> DOUT=0x001F. A[11:10]=3 read -> 0x0000.
- Priority:
  - A_BIT=5, A_CP15=1, OBJ_BIT=2, B_BIT=7 -> index {1,A_COL,5}.
  - A_CP8=1 with A_BIT=5 -> obj wins, index {0,OBJ_COL,2}.
  - A_CP8=1 with A_BIT=9 -> A wins.
- Backdrop: all BIT=0, B_COL=4 -> index 0x140. With G entry 0x140=0x10 -> G=0x84.
- Blanking/latency: HBLANK pulse of 1 pixel -> HB_O and R/G/B=0 exactly 2 CE_PIX later, 1 pixel wide.
- Collision: CPU writes entry 0x100 while video reads 0x100 -> old value that pixel, new value next pixel. LAYER_EN=3'b110 masks A -> B/obj shown.
